dm_responder: RTL and testbench

Data-memory responder on the CPU side's m_data_* interface. It returns read data combinationally and merges byte-enabled stores into a word array. After reset it clears the array with a sweep engine, one word per cycle. Each committed store is pushed into a trace FIFO that a monitor or UART drains through a valid/ready handshake.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/trace_fifo.sv | 79 +++++++
 rtl/dm_responder.sv | 109 ++++++++++
 tb/tb_dm_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: sweep state, trace entry
// layout and the byte-lane merge helper.
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int WORD_BYTES     = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Replace each enabled byte lane of old_word with the matching lane of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byteen);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byteen[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with a valid/ready drain side, a full flag and a
// sticky overflow flag raised when a push is dropped.
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] store_q [DEPTH];
  logic             pop_s, push_ok_s;

  assign valid    = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign head     = store_q[rd_ptr_q];
  assign overflow = overflow_q;

  // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
  always_comb begin
    pop_s      = valid && ready;
    push_ok_s  = push && (!full || pop_s);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~pop_s);
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      store_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: combinational reads, byte-merged stores, a clear
// sweep after reset and a trace FIFO of committed stores.
module dm_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        init_busy,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic [31:0] trc_pc,
  output logic [31:0] trc_addr,
  output logic [31:0] trc_data,
  output logic        trc_overflow
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [31:0]         mem_q [2**ADDR_W];
  logic [ADDR_W-1:0]   idx_s, mem_widx_s;
  logic [31:0]         old_word_s, merged_s, mem_wdata_s;
  logic                mem_we_s, commit_s, trace_full_s, unused_ok;
  trace_entry_t        push_entry_s, head_entry_s;

  assign idx_s        = m_data_addr[ADDR_W+1:2];
  assign old_word_s   = mem_q[idx_s];
  assign merged_s     = merge_lanes(old_word_s, m_data_wdata, m_data_byteen);
  assign m_data_rdata = (state_q == ST_CLEAR) ? 32'd0 : old_word_s;
  assign init_busy    = (state_q == ST_CLEAR);
  assign push_entry_s = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00}, data: merged_s};
  assign unused_ok    = ^{m_data_addr[1:0], trace_full_s};

  // Sweep owns the write port during CLEAR; stores are ignored until IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_s    = 1'b0;
    mem_widx_s  = idx_s;
    mem_wdata_s = merged_s;
    commit_s    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_widx_s  = cnt_q;
        mem_wdata_s = 32'd0;
        cnt_d       = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        commit_s = |m_data_byteen;
        mem_we_s = commit_s;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Sweep state and index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word array; deliberately left out of the asynchronous reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_widx_s] <= mem_wdata_s;
    end
  end

  trace_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (commit_s),
    .push_data (push_entry_s),
    .full      (trace_full_s),
    .valid     (trc_valid),
    .ready     (trc_ready),
    .head      (head_entry_s),
    .overflow  (trc_overflow)
  );

  assign trc_pc   = head_entry_s.pc;
  assign trc_addr = head_entry_s.addr;
  assign trc_data = head_entry_s.data;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: clear sweep, merges,
// address wrap, trace FIFO full/overflow behaviour and reset restart.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
  logic [3:0]  m_data_byteen;
  logic        init_busy, trc_valid, trc_ready, trc_overflow;
  logic [31:0] trc_pc, trc_addr, trc_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_responder dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .init_busy     (init_busy),
    .trc_valid     (trc_valid),
    .trc_ready     (trc_ready),
    .trc_pc        (trc_pc),
    .trc_addr      (trc_addr),
    .trc_data      (trc_data),
    .trc_overflow  (trc_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    m_data_addr   = addr;
    m_data_byteen = 4'h0;
    #1;
    chk(tag, m_data_rdata, exp);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] be, input logic [31:0] pc);
    m_data_addr   = addr;
    m_data_wdata  = wdata;
    m_data_byteen = be;
    m_inst_addr   = pc;
    @(negedge clk);
    m_data_byteen = 4'h0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] pc,
                           input logic [31:0] addr, input logic [31:0] data);
    m_data_byteen = 4'h0;
    chk({tag, "_valid"}, {31'd0, trc_valid}, 32'd1);
    chk({tag, "_pc"}, trc_pc, pc);
    chk({tag, "_addr"}, trc_addr, addr);
    chk({tag, "_data"}, trc_data, data);
    trc_ready = 1'b1;
    @(negedge clk);
    trc_ready = 1'b0;
  endtask

  // Called at the negedge where reset is released; keeps a store pending throughout.
  task automatic sweep(input string tag);
    int   busy  = 0;
    logic rd_ok = 1'b1;
    logic tv_ok = 1'b1;
    m_data_addr   = 32'h10;
    m_data_wdata  = 32'hFFFF_FFFF;
    m_data_byteen = 4'hF;
    m_inst_addr   = 32'h0;
    for (int i = 0; i < 5000; i++) begin
      if (!init_busy) break;
      busy++;
      if (m_data_rdata !== 32'd0) rd_ok = 1'b0;
      if (trc_valid !== 1'b0) tv_ok = 1'b0;
      @(negedge clk);
    end
    m_data_byteen = 4'h0;
    chk({tag, "_busy_cycles"}, busy, 32'd4096);
    chk({tag, "_rdata_zero_in_clear"}, {31'd0, rd_ok}, 32'd1);
    chk({tag, "_no_trace_in_clear"}, {31'd0, tv_ok}, 32'd1);
    rd({tag, "_store_in_clear_ignored"}, 32'h10, 32'd0);
    chk({tag, "_trc_valid_after"}, {31'd0, trc_valid}, 32'd0);
    chk({tag, "_overflow_after"}, {31'd0, trc_overflow}, 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    trc_ready     = 1'b0;
    m_data_addr   = 32'h0;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'h0;
    m_inst_addr   = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_trc_valid", {31'd0, trc_valid}, 32'd0);
    chk("rst_overflow", {31'd0, trc_overflow}, 32'd0);
    reset = 1'b1;
    sweep("init");

    // Full store, then a single-lane merge with a read-during-write check.
    st(32'h20, 32'h1122_3344, 4'hF, 32'h100);
    m_data_addr   = 32'h20;
    m_data_wdata  = 32'h0000_AB00;
    m_data_byteen = 4'b0010;
    m_inst_addr   = 32'h104;
    #1;
    chk("rdw_old_value", m_data_rdata, 32'h1122_3344);
    @(negedge clk);
    m_data_byteen = 4'h0;
    rd("merge_lane1", 32'h20, 32'h1122_AB44);
    pop_check("trc1", 32'h100, 32'h20, 32'h1122_3344);
    pop_check("trc2", 32'h104, 32'h20, 32'h1122_AB44);
    chk("empty_after_two", {31'd0, trc_valid}, 32'd0);

    // Wrapping, unaligned address.
    st(32'h4003, 32'hEE00_0000, 4'b1000, 32'h108);
    rd("wrap_read_idx0", 32'h0, 32'hEE00_0000);
    pop_check("trc_wrap", 32'h108, 32'h4000, 32'hEE00_0000);

    // Zero byte-enable: no write, no push.
    m_data_addr  = 32'h20;
    m_data_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rd("be0_no_write", 32'h20, 32'h1122_AB44);
    chk("be0_no_push", {31'd0, trc_valid}, 32'd0);

    // Fill, push+pop while full, then a dropped push.
    for (int i = 0; i < 8; i++) begin
      st(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 32'h200 + 32'(4 * i));
    end
    chk("full_no_overflow", {31'd0, trc_overflow}, 32'd0);
    trc_ready = 1'b1;
    st(32'h120, 32'hA000_0008, 4'hF, 32'h220);
    trc_ready = 1'b0;
    chk("full_push_pop_no_overflow", {31'd0, trc_overflow}, 32'd0);
    st(32'h124, 32'hA000_0009, 4'hF, 32'h224);
    chk("drop_sets_overflow", {31'd0, trc_overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      pop_check($sformatf("drain%0d", i), 32'h200 + 32'(4 * i),
                32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    end
    chk("drained_empty", {31'd0, trc_valid}, 32'd0);
    chk("overflow_sticky", {31'd0, trc_overflow}, 32'd1);
    rd("dropped_store_written", 32'h124, 32'hA000_0009);
    rd("first_fill_written", 32'h100, 32'hA000_0000);

    // Reset in IDLE, then again at sweep index 2000.
    st(32'h3FFC, 32'hDEAD_BEEF, 4'hF, 32'h300);
    rd("high_word_written", 32'h3FFC, 32'hDEAD_BEEF);
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_overflow_cleared", {31'd0, trc_overflow}, 32'd0);
    chk("rst2_trc_valid", {31'd0, trc_valid}, 32'd0);
    reset = 1'b1;
    repeat (2000) @(negedge clk);
    chk("mid_sweep_busy", {31'd0, init_busy}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sweep("restart");
    rd("high_word_cleared", 32'h3FFC, 32'd0);
    rd("merged_word_cleared", 32'h20, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
